// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined signed complex multiplier, direct (4-mult) or Gauss (3-mult) per transaction.
// Optional define CMUL_CONJ_EN adds a conj input that selects X * conj(Y).
module complex_mul_pipe #(
    parameter  int W  = 8,
    localparam int OW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
`ifdef CMUL_CONJ_EN
    input  logic          conj,
`endif
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] z_r,
    output logic [OW-1:0] z_i,
    output logic          out_mode
);
    localparam int EW = W + 1;
    localparam int PW = 2*W + 2;

    logic          w_advance;
    logic          w_accept;
    logic          w_conj;
    logic [W-1:0]  w_in  [4];
    logic [EW-1:0] w_ext [4];

    logic          r_s1_valid;
    logic          r_s1_mode;
    logic          r_s1_conj;
    logic [EW-1:0] r_s1_op [4];
    logic          r_s2_valid;
    logic          r_s2_mode;
    logic [PW-1:0] r_s2_p1, r_s2_p2, r_s2_p3, r_s2_p4;
    logic          r_s3_valid;
    logic          r_s3_mode;
    logic [OW-1:0] r_s3_zr, r_s3_zi;

    logic [EW-1:0] w_d_eff, w_sum_ab, w_sum_cd, w_m3_x, w_m3_y;
    logic [PW-1:0] w_p1, w_p2, w_p3, w_p4;
    logic [OW-1:0] w_zr, w_zi;

    function automatic logic [PW-1:0] sx(input logic [EW-1:0] v);
        return {{(PW-EW){v[EW-1]}}, v};
    endfunction

    assign w_advance = !r_s3_valid | out_ready;
    assign w_accept  = in_valid & w_advance;
    assign in_ready  = w_advance;

`ifdef CMUL_CONJ_EN
    assign w_conj = conj;
`else
    assign w_conj = 1'b0;
`endif

    assign w_in[0] = a;
    assign w_in[1] = b;
    assign w_in[2] = c;
    assign w_in[3] = d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign w_ext[gi] = {w_in[gi][W-1], w_in[gi]};
        end
    endgenerate

    // Negating after extension keeps d = -2^(W-1) exact under conjugation.
    assign w_d_eff  = r_s1_conj ? -r_s1_op[3] : r_s1_op[3];
    assign w_sum_ab = r_s1_op[0] + r_s1_op[1];
    assign w_sum_cd = r_s1_op[2] + w_d_eff;

    // The third multiplier is shared: a*d in direct mode, (a+b)(c+d) in Gauss mode.
    assign w_m3_x = r_s1_mode ? w_sum_ab : r_s1_op[0];
    assign w_m3_y = r_s1_mode ? w_sum_cd : w_d_eff;

    assign w_p1 = sx(r_s1_op[0]) * sx(r_s1_op[2]);
    assign w_p2 = sx(r_s1_op[1]) * sx(w_d_eff);
    assign w_p3 = sx(w_m3_x) * sx(w_m3_y);
    assign w_p4 = r_s1_mode ? '0 : sx(r_s1_op[1]) * sx(r_s1_op[2]);

    assign w_zr = OW'(r_s2_p1 - r_s2_p2);
    assign w_zi = r_s2_mode ? OW'(r_s2_p3 - r_s2_p1 - r_s2_p2)
                            : OW'(r_s2_p3 + r_s2_p4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_conj  <= 1'b0;
            for (int i = 0; i < 4; i++) r_s1_op[i] <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_p1    <= '0;
            r_s2_p2    <= '0;
            r_s2_p3    <= '0;
            r_s2_p4    <= '0;
            r_s3_valid <= 1'b0;
            r_s3_mode  <= 1'b0;
            r_s3_zr    <= '0;
            r_s3_zi    <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s1_mode  <= mode;
            r_s1_conj  <= w_conj;
            for (int i = 0; i < 4; i++) r_s1_op[i] <= w_ext[i];
            r_s2_valid <= r_s1_valid;
            r_s2_mode  <= r_s1_mode;
            r_s2_p1    <= w_p1;
            r_s2_p2    <= w_p2;
            r_s2_p3    <= w_p3;
            r_s2_p4    <= w_p4;
            r_s3_valid <= r_s2_valid;
            r_s3_mode  <= r_s2_mode;
            r_s3_zr    <= w_zr;
            r_s3_zi    <= w_zi;
        end
    end

    assign out_valid = r_s3_valid;
    assign out_mode  = r_s3_mode;
    assign z_r       = r_s3_zr;
    assign z_i       = r_s3_zi;

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Randomised self-checking bench for complex_mul_pipe against an integer-arithmetic reference model.
module tb_complex_mul_pipe;
    localparam int W  = 8;
    localparam int OW = 2*W+1;

    typedef struct {
        longint zr;
        longint zi;
        logic   mode;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic          conj = 1'b0;
    logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] z_r, z_i;
    logic          out_mode;

    int n_cmp = 0;
    int n_err = 0;

    logic                 obs_acc, obs_got, obs_ir, obs_ov, obs_mode;
    logic signed [OW-1:0] obs_zr, obs_zi;
    res_t                 exp_q[$];

    always #5 clk = ~clk;

    complex_mul_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
`ifdef CMUL_CONJ_EN
        .conj      (conj),
`endif
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_r       (z_r),
        .z_i       (z_i),
        .out_mode  (out_mode)
    );

    // Reference: (a + jb)(c + jd'), d' = -d when conjugating.
    function automatic res_t model(input logic m, input logic signed [W-1:0] ia, ib, ic, id,
                                   input logic cj);
        res_t   r;
        longint la, lb, lc, ld;
        la = ia; lb = ib; lc = ic; ld = id;
        if (cj) ld = -ld;
        r.zr   = la*lc - lb*ld;
        r.zi   = la*ld + lb*lc;
        r.mode = m;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return {1'b1, {(W-1){1'b0}}};
            1:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Drive one cycle at the falling edge and sample the settled outputs 1 time unit later.
    task automatic step(input logic v, input logic m, input logic [W-1:0] ia, ib, ic, id,
                        input logic cj, input logic ordy);
        @(negedge clk);
        in_valid = v; mode = m; a = ia; b = ib; c = ic; d = id; conj = cj; out_ready = ordy;
        #1;
        obs_ir   = in_ready;
        obs_ov   = out_valid;
        obs_acc  = v & in_ready;
        obs_got  = out_valid & ordy;
        obs_zr   = z_r;
        obs_zi   = z_i;
        obs_mode = out_mode;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (z_r !== '0) begin n_err++; $display("FAIL reset_z_r got=%0d want=0", z_r); end
        n_cmp++; if (z_i !== '0) begin n_err++; $display("FAIL reset_z_i got=%0d want=0", z_i); end
        n_cmp++; if (out_mode !== 1'b0) begin n_err++; $display("FAIL reset_out_mode got=%b want=0", out_mode); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        n_cmp++; if (obs_ir !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", obs_ir); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int lat;
        logic got_any;
        for (int m = 0; m < 2; m++) begin
            step(1'b1, m[0], 8'd3, 8'd4, 8'd5, 8'hFE, 1'b0, 1'b1);
            n_cmp++; if (obs_acc !== 1'b1) begin n_err++; $display("FAIL basic_accept mode=%0d got=%b want=1", m, obs_acc); end
            got_any = 1'b0;
            for (lat = 1; lat <= 8 && !got_any; lat++) begin
                step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
                if (obs_got) begin
                    got_any = 1'b1;
                    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL basic_latency mode=%0d got=%0d want=3", m, lat); end
                    n_cmp++; if (obs_zr !== 17'sd23 || obs_zi !== 17'sd14) begin n_err++;
                        $display("FAIL basic_value mode=%0d got=(%0d,%0d) want=(23,14)", m, obs_zr, obs_zi); end
                    n_cmp++; if (obs_mode !== m[0]) begin n_err++; $display("FAIL basic_mode got=%b want=%b", obs_mode, m[0]); end
                end
            end
            if (!got_any) begin n_cmp++; n_err++; $display("FAIL basic_timeout mode=%0d got=none want=result", m); end
            $display("test_basic mode=%0d done", m);
        end
    endtask

    task automatic test_extreme(input logic cj, input longint wzr, input longint wzi);
        int n_got;
        n_got = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 2) step(1'b1, k[0], 8'h80, 8'h80, 8'h80, 8'h80, cj, 1'b1);
            else       step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (obs_got) begin
                n_cmp++;
                if (longint'(obs_zr) != wzr || longint'(obs_zi) != wzi || obs_mode !== n_got[0]) begin n_err++;
                    $display("FAIL extreme conj=%b got=(%0d,%0d,m%b) want=(%0d,%0d,m%b)", cj, obs_zr, obs_zi, obs_mode, wzr, wzi, n_got[0]); end
                n_got++;
            end
        end
        n_cmp++; if (n_got != 2) begin n_err++; $display("FAIL extreme_count got=%0d want=2", n_got); end
        $display("test_extreme conj=%b done", cj);
    endtask

    task automatic test_back_to_back();
        int   n_got, first;
        res_t e;
        logic [W-1:0] ta, tb, tc, td;
        exp_q.delete();
        n_got = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            if (k < 10) begin
                ta = rand_op(); tb = rand_op(); tc = rand_op(); td = rand_op();
                step(1'b1, k[0], ta, tb, tc, td, 1'b0, 1'b1);
                n_cmp++; if (obs_acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept idx=%0d got=%b want=1", k, obs_acc); end
            end else begin
                step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            end
            if (obs_got) begin
                if (first < 0) first = k;
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_unexpected got=(%0d,%0d) want=none", obs_zr, obs_zi); end
                else begin
                    e = exp_q.pop_front();
                    if (obs_zr !== OW'(e.zr) || obs_zi !== OW'(e.zi) || obs_mode !== e.mode || k != first + n_got) begin n_err++;
                        $display("FAIL b2b_result n=%0d got=(%0d,%0d,m%b,cyc%0d) want=(%0d,%0d,m%b,cyc%0d)",
                                 n_got, obs_zr, obs_zi, obs_mode, k, e.zr, e.zi, e.mode, first + n_got); end
                end
                n_got++;
            end
            if (k < 10 && obs_acc) exp_q.push_back(model(k[0], ta, tb, tc, td, 1'b0));
        end
        n_cmp++; if (n_got != 10) begin n_err++; $display("FAIL b2b_count got=%0d want=10", n_got); end
        $display("test_back_to_back done results=%0d", n_got);
    endtask

    task automatic test_stall();
        logic [W-1:0] ta[4], tb[4], tc[4], td[4];
        int   idx, n_got;
        res_t e, first_res;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            ta[k] = rand_op(); tb[k] = rand_op(); tc[k] = rand_op(); td[k] = rand_op();
        end
        first_res = model(1'b0, ta[0], tb[0], tc[0], td[0], 1'b0);
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, idx[0], ta[idx], tb[idx], tc[idx], td[idx], 1'b0, 1'b0);
            if (k >= 3) begin
                n_cmp++; if (obs_ir !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", k, obs_ir); end
                n_cmp++; if (obs_ov !== 1'b1 || obs_zr !== OW'(first_res.zr) || obs_zi !== OW'(first_res.zi)) begin n_err++;
                    $display("FAIL stall_hold cyc=%0d got=(v%b,%0d,%0d) want=(v1,%0d,%0d)", k, obs_ov, obs_zr, obs_zi, first_res.zr, first_res.zi); end
            end
            if (obs_acc) begin
                exp_q.push_back(model(idx[0], ta[idx], tb[idx], tc[idx], td[idx], 1'b0));
                idx++;
            end
        end
        n_cmp++; if (idx != 3) begin n_err++; $display("FAIL stall_accepted got=%0d want=3", idx); end
        n_got = 0;
        for (int k = 0; k < 16; k++) begin
            if (idx < 4) step(1'b1, idx[0], ta[idx], tb[idx], tc[idx], td[idx], 1'b0, 1'b1);
            else         step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (obs_got) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_unexpected got=(%0d,%0d) want=none", obs_zr, obs_zi); end
                else begin
                    e = exp_q.pop_front();
                    if (obs_zr !== OW'(e.zr) || obs_zi !== OW'(e.zi) || obs_mode !== e.mode) begin n_err++;
                        $display("FAIL stall_drain n=%0d got=(%0d,%0d,m%b) want=(%0d,%0d,m%b)", n_got, obs_zr, obs_zi, obs_mode, e.zr, e.zi, e.mode); end
                end
                n_got++;
            end
            if (obs_acc && idx < 4) begin
                exp_q.push_back(model(idx[0], ta[idx], tb[idx], tc[idx], td[idx], 1'b0));
                idx++;
            end
        end
        n_cmp++; if (n_got != 4 || idx != 4) begin n_err++; $display("FAIL stall_total got=(res%0d,acc%0d) want=(res4,acc4)", n_got, idx); end
        $display("test_stall done results=%0d", n_got);
    endtask

    task automatic test_reset_mid();
        int n_got;
        logic got_any;
        step(1'b1, 1'b0, 8'd7, 8'd9, 8'd2, 8'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        n_cmp++; if (obs_ov !== 1'b1) begin n_err++; $display("FAIL midrst_inflight got=%b want=1", obs_ov); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || z_r !== '0) begin n_err++; $display("FAIL midrst_clear got=(v%b,%0d) want=(v0,0)", out_valid, z_r); end
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        n_got = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (obs_ov) n_got++;
        end
        n_cmp++; if (n_got != 0) begin n_err++; $display("FAIL midrst_stale got=%0d want=0", n_got); end
        step(1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 8'd1, 1'b0, 1'b1);
        got_any = 1'b0;
        for (int k = 0; k < 8 && !got_any; k++) begin
            step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (obs_got) begin
                got_any = 1'b1;
                n_cmp++; if (obs_zr !== 17'sd0 || obs_zi !== 17'sd1) begin n_err++;
                    $display("FAIL midrst_next got=(%0d,%0d) want=(0,1)", obs_zr, obs_zi); end
            end
        end
        if (!got_any) begin n_cmp++; n_err++; $display("FAIL midrst_timeout got=none want=result"); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb, tc, td;
        logic tv, tm, tc_j;
        int   n_got, n_acc;
        res_t e;
        exp_q.delete();
        tv = 1'b0; tm = 1'b0; tc_j = 1'b0; ta = '0; tb = '0; tc = '0; td = '0;
        n_got = 0; n_acc = 0;
        for (int k = 0; k < 340; k++) begin
            if (!tv && k < 300 && $urandom_range(0, 3) != 0) begin
                tv = 1'b1; tm = 1'($urandom); ta = rand_op(); tb = rand_op(); tc = rand_op(); td = rand_op();
`ifdef CMUL_CONJ_EN
                tc_j = 1'($urandom);
`endif
            end
            step(tv, tm, ta, tb, tc, td, tc_j, (k >= 300) || ($urandom_range(0, 2) != 0));
            if (obs_got) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL random_unexpected got=(%0d,%0d) want=none", obs_zr, obs_zi); end
                else begin
                    e = exp_q.pop_front();
                    if (obs_zr !== OW'(e.zr) || obs_zi !== OW'(e.zi) || obs_mode !== e.mode) begin n_err++;
                        $display("FAIL random_result n=%0d got=(%0d,%0d,m%b) want=(%0d,%0d,m%b)", n_got, obs_zr, obs_zi, obs_mode, e.zr, e.zi, e.mode); end
                end
                n_got++;
            end
            if (obs_acc) begin
                exp_q.push_back(model(tm, ta, tb, tc, td, tc_j));
                n_acc++;
                tv = 1'b0;
            end
        end
        n_cmp++; if (n_got != n_acc || exp_q.size() != 0) begin n_err++;
            $display("FAIL random_count got=%0d want=%0d left=%0d", n_got, n_acc, exp_q.size()); end
        $display("test_random done accepted=%0d results=%0d", n_acc, n_got);
    endtask

`ifdef CMUL_CONJ_EN
    task automatic test_conj();
        int n_got;
        n_got = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 2) step(1'b1, k[0], 8'd3, 8'd4, 8'd5, 8'hFE, 1'b1, 1'b1);
            else       step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (obs_got) begin
                n_cmp++; if (obs_zr !== 17'sd7 || obs_zi !== 17'sd26 || obs_mode !== n_got[0]) begin n_err++;
                    $display("FAIL conj got=(%0d,%0d,m%b) want=(7,26,m%b)", obs_zr, obs_zi, obs_mode, n_got[0]); end
                n_got++;
            end
        end
        n_cmp++; if (n_got != 2) begin n_err++; $display("FAIL conj_count got=%0d want=2", n_got); end
        $display("test_conj done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_extreme(1'b0, 64'sd0, 64'sd32768);
`ifdef CMUL_CONJ_EN
        test_extreme(1'b1, 64'sd32768, 64'sd0);
        test_conj();
`endif
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
